scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 119 +++++++++++
 tb/tb_scan_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//   Registered one-hot decoder. It decodes a manual select index, or it scans
//   automatically through indices 0..scan_last, advancing once every SCAN_DIV
//   clock cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | disabled or just reset; y inactive, idx=0, no pulses
//   MANUAL | y/idx follow sel with one cycle of latency
//   SCAN   | prescaler counts 0..SCAN_DIV-1; idx advances on terminal count
//
// Parameters
//   SEL_W      select width; y is 2**SEL_W bits wide
//   ACTIVE_LOW 1 inverts every bit of y
//   SCAN_DIV   clk cycles per scan step (1..65535)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         enable; 0 forces IDLE on the next edge
//   mode       0 = manual decode of sel, 1 = auto scan
//   sel        manual select index
//   scan_last  highest index visited while scanning
//   y          registered one-hot decode
//   idx        index currently driven on y
//   step       one-cycle pulse when the scan index advances
//   wrap       one-cycle pulse when an advance lands on index 0
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int SEL_W      = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int SCAN_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [SEL_W-1:0]      scan_last,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  step,
    output logic                  wrap
);

    localparam int              N          = 2**SEL_W;
    localparam logic [N-1:0]    Y_IDLE     = {N{ACTIVE_LOW}};
    localparam logic [15:0]     PRESC_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      presc;
    logic [SEL_W-1:0] idx_adv;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    // Any idx at or above scan_last (including one left stranded when
    // scan_last is lowered mid-scan) wraps back to 0 on the next advance.
    always_comb begin
        idx_adv = '0;
        if (idx < scan_last)
            idx_adv = idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            idx   <= '0;
            y     <= Y_IDLE;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            presc <= '0;
            idx   <= '0;
            y     <= Y_IDLE;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state <= MANUAL;
            presc <= '0;
            idx   <= sel;
            y     <= decode(sel);
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (state != SCAN) begin
            // Entering the scan always starts fresh at index 0.
            state <= SCAN;
            presc <= '0;
            idx   <= '0;
            y     <= decode('0);
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx_adv;
            y     <= decode(idx_adv);
            step  <= 1'b1;
            wrap  <= (idx_adv == '0);
        end else begin
            presc <= presc + 16'd1;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
//   Directed bench for scan_decoder. Three instances cover the default
//   configuration (manual, scan, wrap, lowered scan_last, async reset), the
//   active-low polarity, and the SCAN_DIV=1 / scan_last=0 boundary.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // instance A: defaults (ACTIVE_LOW=0, SCAN_DIV=4)
    logic        a_rst_n, a_en, a_mode;
    logic [3:0]  a_sel, a_last, a_idx;
    logic [15:0] a_y;
    logic        a_step, a_wrap;

    scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode), .sel(a_sel),
        .scan_last(a_last), .y(a_y), .idx(a_idx), .step(a_step), .wrap(a_wrap)
    );

    // instance B: active-low outputs
    logic        b_rst_n, b_en, b_mode;
    logic [3:0]  b_sel, b_last, b_idx;
    logic [15:0] b_y;
    logic        b_step, b_wrap;

    scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b1), .SCAN_DIV(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .sel(b_sel),
        .scan_last(b_last), .y(b_y), .idx(b_idx), .step(b_step), .wrap(b_wrap)
    );

    // instance C: SCAN_DIV=1
    logic        c_rst_n, c_en, c_mode;
    logic [3:0]  c_sel, c_last, c_idx;
    logic [15:0] c_y;
    logic        c_step, c_wrap;

    scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0), .SCAN_DIV(1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .mode(c_mode), .sel(c_sel),
        .scan_last(c_last), .y(c_y), .idx(c_idx), .step(c_step), .wrap(c_wrap)
    );

    initial begin
        int steps;
        int wraps;
        int exp_idx;
        bit found;

        a_rst_n = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_sel = 4'd0; a_last = 4'd0;
        b_rst_n = 1'b0; b_en = 1'b0; b_mode = 1'b0; b_sel = 4'd0; b_last = 4'd0;
        c_rst_n = 1'b0; c_en = 1'b0; c_mode = 1'b0; c_sel = 4'd0; c_last = 4'd0;

        repeat (2) cyc();
        check("rst_y",    32'(a_y),    32'h0000);
        check("rst_idx",  32'(a_idx),  32'd0);
        check("rst_step", 32'(a_step), 32'd0);
        check("rst_wrap", 32'(a_wrap), 32'd0);
        check("rst_y_al", 32'(b_y),    32'hFFFF);

        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

        // ---------------- manual decode
        a_en = 1'b1; a_mode = 1'b0; a_sel = 4'd9;
        cyc();
        check("man9_y",   32'(a_y),   32'h0200);
        check("man9_idx", 32'(a_idx), 32'd9);
        a_sel = 4'd15;
        cyc();
        check("man15_y",   32'(a_y),   32'h8000);
        check("man15_idx", 32'(a_idx), 32'd15);
        check("man_step",  32'(a_step), 32'd0);

        // ---------------- scan 0,1,2,3,0 with 4 cycles per index
        a_mode = 1'b1; a_last = 4'd3;
        steps = 0; wraps = 0;
        for (int k = 0; k <= 16; k++) begin
            cyc();
            exp_idx = (k / 4) % 4;
            check($sformatf("scan_idx_k%0d", k), 32'(a_idx), 32'(exp_idx));
            check($sformatf("scan_y_k%0d", k), 32'(a_y), 32'h1 << exp_idx);
            if (a_step) steps++;
            if (a_wrap) wraps++;
        end
        check("scan_steps", 32'(steps), 32'd4);
        check("scan_wraps", 32'(wraps), 32'd1);
        check("scan_wrap_at_0", 32'(a_wrap), 32'd1);

        // ---------------- lower scan_last from 10 to 2 while idx=6
        a_last = 4'd10;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (a_idx == 4'd6) found = 1'b1;
        end
        check("reach_idx6", 32'(found), 32'd1);
        a_last = 4'd2;
        repeat (3) cyc();
        check("lower_hold_idx", 32'(a_idx), 32'd6);
        cyc();
        check("lower_idx",  32'(a_idx),  32'd0);
        check("lower_wrap", 32'(a_wrap), 32'd1);
        check("lower_step", 32'(a_step), 32'd1);
        check("lower_y",    32'(a_y),    32'h0001);

        // ---------------- async reset mid-scan at idx=5
        a_last = 4'd10;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (a_idx == 4'd5) found = 1'b1;
        end
        check("reach_idx5", 32'(found), 32'd1);
        #2 a_rst_n = 1'b0;
        #1;
        check("arst_y",    32'(a_y),    32'h0000);
        check("arst_idx",  32'(a_idx),  32'd0);
        check("arst_step", 32'(a_step), 32'd0);
        cyc();
        a_rst_n = 1'b1;
        cyc();
        check("arst_restart_idx",  32'(a_idx),  32'd0);
        check("arst_restart_y",    32'(a_y),    32'h0001);
        check("arst_restart_step", 32'(a_step), 32'd0);
        repeat (4) cyc();
        check("arst_adv_idx",  32'(a_idx),  32'd1);
        check("arst_adv_step", 32'(a_step), 32'd1);
        check("arst_adv_wrap", 32'(a_wrap), 32'd0);

        // ---------------- active-low polarity
        b_en = 1'b1; b_mode = 1'b0; b_sel = 4'd0;
        cyc();
        check("al_man0_y", 32'(b_y), 32'hFFFE);
        b_en = 1'b0; b_mode = 1'b1;
        cyc();
        check("al_dis_y",   32'(b_y),   32'hFFFF);
        check("al_dis_idx", 32'(b_idx), 32'd0);

        // ---------------- SCAN_DIV=1, scan_last=0
        c_en = 1'b1; c_mode = 1'b1; c_last = 4'd0;
        cyc();
        check("d1_entry_y",    32'(c_y),    32'h0001);
        check("d1_entry_step", 32'(c_step), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("d1_step_k%0d", k), 32'(c_step), 32'd1);
            check($sformatf("d1_wrap_k%0d", k), 32'(c_wrap), 32'd1);
            check($sformatf("d1_y_k%0d", k),    32'(c_y),    32'h0001);
        end
        c_en = 1'b0;
        cyc();
        check("d1_dis_y",    32'(c_y),    32'h0000);
        check("d1_dis_step", 32'(c_step), 32'd0);
        c_en = 1'b1;
        cyc();
        check("d1_restart_idx",  32'(c_idx),  32'd0);
        check("d1_restart_y",    32'(c_y),    32'h0001);
        check("d1_restart_step", 32'(c_step), 32'd0);
        cyc();
        check("d1_resume_step", 32'(c_step), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
